// File: rtl/fifo_rr_arb.sv
// ---------------------------------------------------------------------------
// fifo_rr_arb
//
// Round-robin arbiter that merges NUM valid/ready requester streams into one
// registered output stream. The output stage is a single register slice, so
// the winning beat appears on dout_* exactly one cycle after its handshake.
//
// The grant search starts one above the most recently granted requester and
// wraps. With every requester continuously valid, each one therefore wins once
// in every NUM consecutive grants.
//
// Optional feature (macro FIFO_RR_ARB_LOCK_EN):
//   A packet lock. Once a requester's first beat is accepted with din_eot=0,
//   that requester keeps the grant until its din_eot=1 beat is accepted.
//   Without the macro, arbitration is redone on every beat and din_eot is only
//   carried through to dout_eot.
//
// Parameters:
//   NUM - number of requesters (2..8)
//   DIN - data width per requester
//
// Ports:
//   clk        in   clock; every flop uses its rising edge
//   rst        in   synchronous, active-high reset
//   din_valid  in   [NUM]      per-requester valid
//   din_ready  out  [NUM]      per-requester ready; only the granted bit can be 1
//   din_data   in   [NUM*DIN]  requester i data at bits [i*DIN +: DIN]
//   din_eot    in   [NUM]      per-requester last-beat-of-packet flag
//   dout_valid out             registered output valid
//   dout_ready in              downstream ready
//   dout_data  out  [DIN]      registered winning data
//   dout_sel   out  [clog2]    index of the requester that sourced dout_data
//   dout_eot   out             registered eot of the winning beat
// ---------------------------------------------------------------------------
module fifo_rr_arb #(
    parameter int NUM = 4,
    parameter int DIN = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM-1:0]          din_valid,
    output logic [NUM-1:0]          din_ready,
    input  logic [NUM*DIN-1:0]      din_data,
    input  logic [NUM-1:0]          din_eot,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic [DIN-1:0]          dout_data,
    output logic [$clog2(NUM)-1:0]  dout_sel,
    output logic                    dout_eot
);

    localparam int SW = $clog2(NUM);

    // Output register slice and round-robin pointer.
    logic           dout_valid_q, dout_valid_d;
    logic [DIN-1:0] dout_data_q,  dout_data_d;
    logic [SW-1:0]  dout_sel_q,   dout_sel_d;
    logic           dout_eot_q,   dout_eot_d;
    logic [SW-1:0]  ptr_q,        ptr_d;

    // Combinational arbitration results.
    logic           ld_s;        // output slice can take a new beat this cycle
    logic           rr_found_s;  // round-robin search found a valid requester
    logic [SW-1:0]  rr_idx_s;    // round-robin winner
    logic [SW-1:0]  sel_idx_s;   // requester granted this cycle
    logic           sel_en_s;    // a grant exists (ready may be driven)
    logic           hs_s;        // input handshake on sel_idx_s
    logic [NUM-1:0] onehot_s;
    logic [NUM-1:0] din_ready_s;

`ifdef FIFO_RR_ARB_LOCK_EN
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]     state_q,    state_d;
    logic [SW-1:0]  lock_idx_q, lock_idx_d;
`endif

    // The slice accepts a beat when empty or when its current beat drains.
    always_comb begin
        ld_s = !dout_valid_q || dout_ready;
    end

    // Round-robin search: first valid requester above ptr_q, wrapping.
    always_comb begin
        logic [SW-1:0] cand;
        rr_found_s = 1'b0;
        rr_idx_s   = ptr_q;
        cand       = ptr_q;
        for (int k = 1; k <= NUM; k++) begin
            cand = SW'((int'(ptr_q) + k) % NUM);
            if (!rr_found_s && din_valid[cand]) begin
                rr_found_s = 1'b1;
                rr_idx_s   = cand;
            end else begin
                rr_found_s = rr_found_s;
            end
        end
    end

    // Pick the grant: the lock owner while a packet is open, else the RR winner.
    always_comb begin
        sel_idx_s = rr_idx_s;
        sel_en_s  = rr_found_s;
`ifdef FIFO_RR_ARB_LOCK_EN
        if (state_q == ST_LOCKED) begin
            // The owner's ready is driven even while its valid is low.
            sel_idx_s = lock_idx_q;
            sel_en_s  = 1'b1;
        end else begin
            sel_idx_s = rr_idx_s;
            sel_en_s  = rr_found_s;
        end
`endif
    end

    // Ready goes only to the granted requester. It is held low during reset.
    always_comb begin
        onehot_s    = {{(NUM-1){1'b0}}, 1'b1} << sel_idx_s;
        din_ready_s = {NUM{1'b0}};
        if (rst) begin
            din_ready_s = {NUM{1'b0}};
        end else if (sel_en_s && ld_s) begin
            din_ready_s = onehot_s;
        end else begin
            din_ready_s = {NUM{1'b0}};
        end
        hs_s = !rst && sel_en_s && ld_s && din_valid[sel_idx_s];
    end

    // Next state of the output slice and the round-robin pointer.
    always_comb begin
        dout_valid_d = dout_valid_q;
        dout_data_d  = dout_data_q;
        dout_sel_d   = dout_sel_q;
        dout_eot_d   = dout_eot_q;
        ptr_d        = ptr_q;
        if (rst) begin
            // Data is left as-is; after reset it carries no meaning.
            dout_valid_d = 1'b0;
            dout_sel_d   = {SW{1'b0}};
            dout_eot_d   = 1'b0;
            ptr_d        = SW'(NUM - 1);
        end else if (hs_s) begin
            dout_valid_d = 1'b1;
            dout_data_d  = din_data[int'(sel_idx_s)*DIN +: DIN];
            dout_sel_d   = sel_idx_s;
            dout_eot_d   = din_eot[sel_idx_s];
            ptr_d        = sel_idx_s;
        end else if (dout_ready) begin
            dout_valid_d = 1'b0;
        end else begin
            dout_valid_d = dout_valid_q;
        end
    end

`ifdef FIFO_RR_ARB_LOCK_EN
    // Packet lock FSM. A single-beat packet (eot in IDLE) never locks.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        if (rst) begin
            state_d    = ST_IDLE;
            lock_idx_d = {SW{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hs_s && !din_eot[sel_idx_s]) begin
                        state_d    = ST_LOCKED;
                        lock_idx_d = sel_idx_s;
                    end else begin
                        state_d    = ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (hs_s && din_eot[sel_idx_s]) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Lock FSM state registers.
    always_ff @(posedge clk) begin
        state_q    <= state_d;
        lock_idx_q <= lock_idx_d;
    end
`endif

    // Output slice and pointer registers; reset is folded into the _d logic.
    always_ff @(posedge clk) begin
        dout_valid_q <= dout_valid_d;
        dout_data_q  <= dout_data_d;
        dout_sel_q   <= dout_sel_d;
        dout_eot_q   <= dout_eot_d;
        ptr_q        <= ptr_d;
    end

    // Drive the output ports.
    always_comb begin
        din_ready  = din_ready_s;
        dout_valid = dout_valid_q;
        dout_data  = dout_data_q;
        dout_sel   = dout_sel_q;
        dout_eot   = dout_eot_q;
    end

endmodule

// File: tb/tb_fifo_rr_arb.sv
// ---------------------------------------------------------------------------
// tb_fifo_rr_arb
//
// Self-checking bench for fifo_rr_arb with NUM=4 and DIN=16.
//   - A directed vector table covers reset, a single requester, the full
//     rotation and backpressure hold/drain.
//   - Hand-written sequences cover the packet lock (or interleaving) and a
//     reset in the middle of a packet.
//   - A randomized run is checked against a behavioural reference model.
// When FIFO_RR_ARB_LOCK_EN is defined, the model and expectations use lock mode.
// ---------------------------------------------------------------------------
module tb_fifo_rr_arb;

`ifdef FIFO_RR_ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  din_valid;
    logic [3:0]  din_ready;
    logic [63:0] din_data;
    logic [3:0]  din_eot;
    logic        dout_valid;
    logic        dout_ready;
    logic [15:0] dout_data;
    logic [1:0]  dout_sel;
    logic        dout_eot;

    fifo_rr_arb #(.NUM(4), .DIN(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_data   (din_data),
        .din_eot    (din_eot),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data),
        .dout_sel   (dout_sel),
        .dout_eot   (dout_eot)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the output slice should hold, which
    // requester was granted most recently, and any open packet lock.
    bit          m_valid  = 1'b0;
    logic [15:0] m_data   = 16'h0;
    int          m_sel    = 0;
    bit          m_eot    = 1'b0;
    int          m_last   = 3;
    bit          m_locked = 1'b0;
    int          m_owner  = 0;

    // Values observed during the most recent step().
    logic [3:0]  obs_ready;
    logic        obs_valid;
    logic [15:0] obs_data;
    logic [1:0]  obs_sel;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Runs one clock cycle. Drives the inputs at negedge, checks din_ready
    // against the model, lets the edge pass, then checks the outputs.
    task automatic step(input logic [3:0] v, input logic [63:0] d, input logic [3:0] e,
                        input logic rdy, input logic r);
        int   g;
        bit   ld;
        bit   hs;
        logic [3:0] er;
        @(negedge clk);
        din_valid  = v;
        din_data   = d;
        din_eot    = e;
        dout_ready = rdy;
        rst        = r;
        #1;
        ld = !m_valid || rdy;
        g  = -1;
        if (!r) begin
            if (LOCK && m_locked) begin
                g = m_owner;
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    if (g < 0 && v[(m_last + k) % 4]) g = (m_last + k) % 4;
                end
            end
        end
        er = 4'b0000;
        if (g >= 0 && ld) er[g] = 1'b1;
        obs_ready = din_ready;
        chk("din_ready", din_ready, er);
        hs = (g >= 0) && ld && v[g];
        @(posedge clk);
        #1;
        if (r) begin
            m_valid = 1'b0; m_sel = 0; m_eot = 1'b0; m_last = 3; m_locked = 1'b0;
        end else if (hs) begin
            m_valid = 1'b1;
            m_data  = d[g*16 +: 16];
            m_sel   = g;
            m_eot   = e[g];
            m_last  = g;
            if (LOCK) begin
                if (!m_locked && !e[g]) begin
                    m_locked = 1'b1;
                    m_owner  = g;
                end else if (m_locked && e[g]) begin
                    m_locked = 1'b0;
                end
            end
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        obs_valid = dout_valid;
        obs_data  = dout_data;
        obs_sel   = dout_sel;
        chk("dout_valid", dout_valid, m_valid);
        if (r) begin
            chk("rst_dout_sel", dout_sel, 0);
            chk("rst_dout_eot", dout_eot, 0);
        end
        if (m_valid) begin
            chk("dout_data", dout_data, m_data);
            chk("dout_sel",  dout_sel,  m_sel);
            chk("dout_eot",  dout_eot,  m_eot);
        end
    endtask

    typedef struct {
        logic [3:0]  v;
        logic [63:0] d;
        logic        rdy;
        logic        r;
        logic [3:0]  er;   // expected din_ready before the edge
        logic        ev;   // expected dout_valid after the edge
        logic [1:0]  es;   // expected dout_sel (when ev)
        logic [15:0] ed;   // expected dout_data (when ev)
    } vec_t;

    localparam logic [63:0] DPAT = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    localparam logic [63:0] DA5  = {16'h4444, 16'hA5A5, 16'h2222, 16'h1111};

    function automatic vec_t mk(input logic [3:0] v, input logic [63:0] d, input logic rdy,
                                input logic r, input logic [3:0] er, input logic ev,
                                input logic [1:0] es, input logic [15:0] ed);
        vec_t t;
        t.v = v; t.d = d; t.rdy = rdy; t.r = r; t.er = er; t.ev = ev; t.es = es; t.ed = ed;
        return t;
    endfunction

    vec_t tbl [17];

    initial begin
        int left1;
        int left0;
        int left2;
        int sels [$];
        int exp_sels [5];
        logic [3:0] v;
        logic [3:0] e;

        rst = 1'b1; din_valid = 4'b0; din_data = 64'h0; din_eot = 4'b0; dout_ready = 1'b1;

        // ---------------- directed vector table ----------------
        tbl[0]  = mk(4'b0000, DPAT, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0);
        tbl[1]  = mk(4'b0100, DA5,  1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 16'hA5A5);
        tbl[2]  = mk(4'b1111, DPAT, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0);
        tbl[3]  = mk(4'b1111, DPAT, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 16'h1111);
        tbl[4]  = mk(4'b1111, DPAT, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 16'h2222);
        tbl[5]  = mk(4'b1111, DPAT, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 16'h3333);
        tbl[6]  = mk(4'b1111, DPAT, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 16'h4444);
        tbl[7]  = mk(4'b1111, DPAT, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 16'h1111);
        tbl[8]  = mk(4'b1111, DPAT, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 16'h2222);
        for (int i = 9; i <= 13; i++)
            tbl[i] = mk(4'b0011, DPAT, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 16'h2222);
        tbl[14] = mk(4'b0011, DPAT, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 16'h1111);
        tbl[15] = mk(4'b0011, DPAT, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 16'h2222);
        tbl[16] = mk(4'b0000, DPAT, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 16'h0);

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].v, tbl[i].d, 4'b1111, tbl[i].rdy, tbl[i].r);
            chk($sformatf("tbl%0d_ready", i), obs_ready, tbl[i].er);
            chk($sformatf("tbl%0d_valid", i), obs_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_sel", i),  obs_sel,  tbl[i].es);
                chk($sformatf("tbl%0d_data", i), obs_data, tbl[i].ed);
            end
        end

        // ---------------- packet lock / interleave sequence ----------------
        // Requester 1 sends a 3-beat packet. Requesters 0 and 2 each send one
        // single-beat packet, starting one cycle after requester 1.
        step(4'b0000, DPAT, 4'b0000, 1'b1, 1'b1);
        left1 = 3; left0 = 1; left2 = 1;
        if (LOCK) exp_sels = '{1, 1, 1, 2, 0};
        else      exp_sels = '{1, 2, 0, 1, 1};
        for (int c = 0; c < 20 && sels.size() < 5; c++) begin
            v = 4'b0000;
            v[1] = (left1 > 0);
            v[0] = (c > 0) && (left0 > 0);
            v[2] = (c > 0) && (left2 > 0);
            e = 4'b1111;
            e[1] = (left1 == 1);
            step(v, DPAT, e, 1'b1, 1'b0);
            if (obs_ready[1] && v[1]) left1--;
            if (obs_ready[0] && v[0]) left0--;
            if (obs_ready[2] && v[2]) left2--;
            if (obs_valid) sels.push_back(int'(obs_sel));
        end
        chk("pkt_beats", sels.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < sels.size()) chk($sformatf("pkt_sel%0d", i), sels[i], exp_sels[i]);
        end

        // ---------------- reset in the middle of a packet ----------------
        step(4'b0000, DPAT, 4'b0000, 1'b1, 1'b1);
        step(4'b1000, DPAT, 4'b0000, 1'b1, 1'b0);   // requester 3 opens a packet
        chk("mid_sel3", obs_sel, 2'd3);
        step(4'b1000, DPAT, 4'b0000, 1'b1, 1'b1);   // reset while it is open
        chk("mid_rst_valid", obs_valid, 1'b0);
        step(4'b1001, DPAT, 4'b0000, 1'b1, 1'b0);
        chk("mid_ready0", obs_ready, 4'b0001);
        chk("mid_sel0", obs_sel, 2'd0);

        // ---------------- randomized run vs. model ----------------
        step(4'b0000, DPAT, 4'b0000, 1'b1, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            step(4'($urandom_range(0, 15)),
                 {$urandom, $urandom},
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 199) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
